// File: rtl/seg7_scan_decoder_if.sv
// Signal bundle between a multiplexed 7-segment display scan and its decoder.
//   master : drives the scan side (seg, an) and observes the decoded outputs
//   slave  : the decoder; samples seg/an and drives digits, pulses and counts
//   seg         [0:6] active-low segments, seg[0]=a .. seg[6]=g
//   an          [3:0] active-low anodes, an[0]=minutes ones .. an[3]=hours tens
//   digit0..3   last complete decoded frame, 0-9 or 4'hF for blank
//   frame_valid one-cycle pulse when digit0..3 update
//   dec_err     one-cycle pulse on an illegal segment or anode pattern
//   err_count   saturating error count, frame_count wrapping frame count
interface seg7_scan_decoder_if;
   logic [0:6] seg;
   logic [3:0] an;
   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic [3:0] digit3;
   logic       frame_valid;
   logic       dec_err;
   logic [7:0] err_count;
   logic [7:0] frame_count;

   modport master (
      output seg, an,
      input  digit0, digit1, digit2, digit3, frame_valid, dec_err, err_count, frame_count
   );

   modport slave (
      input  seg, an,
      output digit0, digit1, digit2, digit3, frame_valid, dec_err, err_count, frame_count
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers the four digits of a multiplexed 7-segment clock display by
// watching its segment and anode lines. Each anode dwell is allowed to settle
// for SETTLE_CYCLES stable cycles, then sampled exactly once; a frame is
// published when all four slots have been captured since the last publish.
//
// Ports: clk_100Mhz (only clock, rising edge), reset (async, active-high),
//        bus (seg7_scan_decoder_if.slave: seg/an in, digits/pulses/counts out).
// Optional build macro SEG7_DEC_STATS_EN: adds the saturating error counter
// and wrapping frame counter; without it err_count and frame_count read 0.
//
// state   | meaning
// WAIT_AN | no single anode active yet (all off or illegal multi-anode)
// SETTLE  | one anode active, counting stable cycles before sampling
// SAMPLE  | single cycle: decode seg_q into the selected slot
// HOLD    | dwell already sampled, wait for the anode to change
module seg7_scan_decoder #(
   parameter int SETTLE_CYCLES = 16
) (
   input  logic               clk_100Mhz,
   input  logic               reset,
   seg7_scan_decoder_if.slave bus
);
   typedef enum logic [1:0] {WAIT_AN, SETTLE, SAMPLE, HOLD} state_t;

   localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

   state_t     state, state_nxt;
   logic [0:6] seg_q;
   logic [3:0] an_q, an_prev;
   logic [7:0] cnt, cnt_nxt;
   logic [3:0] mask, mask_upd;
   logic [3:0] slot  [4];
   logic [3:0] digit [4];
   logic       frame_valid_r, dec_err_r;

   logic       an_changed, an_one_cold, an_multi;
   logic [1:0] sel;
   logic       an_err, do_sample;
   logic [6:0] gfedcba;
   logic [3:0] dec_val;
   logic       dec_ok;

   assign an_changed = (an_q != an_prev);

   always_comb begin
      an_one_cold = 1'b1;
      sel         = 2'd0;
      case (an_q)
         4'b1110: sel = 2'd0;
         4'b1101: sel = 2'd1;
         4'b1011: sel = 2'd2;
         4'b0111: sel = 2'd3;
         default: an_one_cold = 1'b0;
      endcase
   end

   assign an_multi = !an_one_cold && (an_q != 4'b1111);

   // A changed anode always re-enters WAIT_AN evaluation, which also cancels a
   // pending sample. Multi-anode errors fire only on the change so a held
   // illegal pattern reports once.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      an_err    = 1'b0;
      do_sample = 1'b0;
      if (state == WAIT_AN || an_changed) begin
         if (an_one_cold) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
         end else begin
            state_nxt = WAIT_AN;
            an_err    = an_multi && an_changed;
         end
      end else begin
         case (state)
            SETTLE: begin
               if (cnt == CNT_LAST) state_nxt = SAMPLE;
               else                 cnt_nxt   = cnt + 8'd1;
            end
            SAMPLE: begin
               do_sample = 1'b1;
               state_nxt = HOLD;
            end
            default: state_nxt = HOLD;
         endcase
      end
   end

   // seg_q is [0:6] with a first; reorder to the g..a reading of the table.
   assign gfedcba = {seg_q[6], seg_q[5], seg_q[4], seg_q[3], seg_q[2], seg_q[1], seg_q[0]};

   always_comb begin
      dec_ok  = 1'b1;
      dec_val = 4'hF;
      case (gfedcba)
         7'b1000000: dec_val = 4'd0;
         7'b1111001: dec_val = 4'd1;
         7'b0100100: dec_val = 4'd2;
         7'b0110000: dec_val = 4'd3;
         7'b0011001: dec_val = 4'd4;
         7'b0010010: dec_val = 4'd5;
         7'b0000010: dec_val = 4'd6;
         7'b1111000: dec_val = 4'd7;
         7'b0000000: dec_val = 4'd8;
         7'b0010000: dec_val = 4'd9;
         7'b1111111: dec_val = 4'hF;
         default:    dec_ok  = 1'b0;
      endcase
   end

   assign mask_upd = mask | (4'b0001 << sel);

   always_ff @(posedge clk_100Mhz or posedge reset) begin
      if (reset) begin
         state         <= WAIT_AN;
         seg_q         <= '0;
         an_q          <= 4'b1111;
         an_prev       <= 4'b1111;
         cnt           <= '0;
         mask          <= '0;
         frame_valid_r <= 1'b0;
         dec_err_r     <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            slot[i]  <= '0;
            digit[i] <= '0;
         end
      end else begin
         seg_q         <= bus.seg;
         an_q          <= bus.an;
         an_prev       <= an_q;
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         frame_valid_r <= 1'b0;
         dec_err_r     <= an_err || (do_sample && !dec_ok);
         if (do_sample) begin
            if (!dec_ok) begin
               mask <= '0;
            end else begin
               slot[sel] <= dec_val;
               if (mask_upd == 4'b1111) begin
                  // Publish with the just-decoded value merged in.
                  for (int i = 0; i < 4; i++)
                     digit[i] <= (2'(i) == sel) ? dec_val : slot[i];
                  frame_valid_r <= 1'b1;
                  mask          <= '0;
               end else begin
                  mask <= mask_upd;
               end
            end
         end
      end
   end

   assign bus.digit0      = digit[0];
   assign bus.digit1      = digit[1];
   assign bus.digit2      = digit[2];
   assign bus.digit3      = digit[3];
   assign bus.frame_valid = frame_valid_r;
   assign bus.dec_err     = dec_err_r;

`ifdef SEG7_DEC_STATS_EN
   logic [7:0] err_cnt, frm_cnt;

   always_ff @(posedge clk_100Mhz or posedge reset) begin
      if (reset) begin
         err_cnt <= '0;
         frm_cnt <= '0;
      end else begin
         if (dec_err_r && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         if (frame_valid_r)                 frm_cnt <= frm_cnt + 8'd1;
      end
   end

   assign bus.err_count   = err_cnt;
   assign bus.frame_count = frm_cnt;
`else
   assign bus.err_count   = '0;
   assign bus.frame_count = '0;
`endif
endmodule
